// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// The master drives load/mode/enable/abort; the slave (the timer) returns count and status.
interface countdown_timer_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             oneshot;
   logic             en;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, oneshot, en, stop,
      input  count, tick, busy, done
   );

   modport slave (
      input  load, load_val, oneshot, en, stop,
      output count, tick, busy, done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter producing a one-cycle tick at terminal count.
// Periodic mode reloads from the captured value; one-shot mode parks in DONE.
// All outputs come straight from flops, so no input reaches an output combinationally.
module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   countdown_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_mode;     // 1 = one-shot, 0 = periodic
   logic             r_tick;
   logic             r_busy;
   logic             r_done;

   // State, count and registered status outputs; load beats stop beats counting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_count  <= ZERO;
         r_reload <= ZERO;
         r_mode   <= 1'b0;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else if (bus.load) begin
         // Restart from the new value; any tick due this edge is dropped.
         r_state  <= ST_RUN;
         r_count  <= bus.load_val;
         r_reload <= bus.load_val;
         r_mode   <= bus.oneshot;
         r_tick   <= 1'b0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
      end else if (bus.stop) begin
         // Abort keeps reload and mode so a later load is the only restart path.
         r_state  <= ST_IDLE;
         r_count  <= ZERO;
         r_tick   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.en) begin
                  if (r_count != ZERO) begin
                     r_count <= r_count - ONE;
                     r_tick  <= 1'b0;
                  end else begin
                     // Terminal count: zero is never decremented, so no wrap.
                     r_tick <= 1'b1;
                     if (r_mode) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_count <= r_reload;
                     end
                  end
               end else begin
                  r_tick <= 1'b0;
               end
            end
            ST_IDLE, ST_DONE: begin
               r_tick <= 1'b0;
            end
            default: begin
               // Unreachable encoding: fall back to a clean idle.
               r_state <= ST_IDLE;
               r_count <= ZERO;
               r_tick  <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.count = r_count;
   assign bus.tick  = r_tick;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: elapsed-cycle reference model compared every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_countdown_timer;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   countdown_timer_if #(.WIDTH(8)) u_if ();

   countdown_timer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
   );

   always #5 clk = ~clk;

   // Reference model: phase (0 idle, 1 run, 2 done), loaded N, mode,
   // number of enabled RUN edges since the load, and whether the last edge ticked.
   int m_ph   = 0;
   int m_n    = 0;
   int m_os   = 0;
   int m_e    = 0;
   int m_tick = 0;

   function automatic int exp_count();
      if (m_ph == 1) begin
         if (m_os != 0) return m_n - m_e;
         return m_n - (m_e % (m_n + 1));
      end
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each clock edge / asynchronous reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ph <= 0; m_n <= 0; m_os <= 0; m_e <= 0; m_tick <= 0;
      end else if (u_if.load) begin
         m_ph <= 1; m_n <= int'(u_if.load_val); m_os <= int'(u_if.oneshot);
         m_e <= 0; m_tick <= 0;
      end else if (u_if.stop) begin
         m_ph <= 0; m_tick <= 0;
      end else if (m_ph == 1 && u_if.en) begin
         if (m_os != 0) begin
            if (m_e == m_n) begin
               m_ph <= 2; m_tick <= 1;
            end else begin
               m_e <= m_e + 1; m_tick <= 0;
            end
         end else begin
            m_e    <= m_e + 1;
            m_tick <= (((m_e + 1) % (m_n + 1)) == 0) ? 1 : 0;
         end
      end else begin
         m_tick <= 0;
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      chk("cmp_count", int'(u_if.count), exp_count());
      chk("cmp_tick",  int'(u_if.tick),  m_tick);
      chk("cmp_busy",  int'(u_if.busy),  (m_ph == 1) ? 1 : 0);
      chk("cmp_done",  int'(u_if.done),  (m_ph == 2) ? 1 : 0);
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) @(posedge clk);
      #1;
   endtask

   int pc [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
   int pt [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
   int qc [7] = '{3, 2, 2, 2, 1, 0, 3};
   int qt [7] = '{0, 0, 0, 0, 0, 0, 1};
   int qe [6] = '{1, 0, 0, 1, 1, 1};
   int oc [4] = '{2, 1, 0, 0};
   int ot [4] = '{0, 0, 0, 1};
   int ob [4] = '{1, 1, 1, 0};
   int mc [5] = '{1, 0, 1, 0, 1};
   int mt [5] = '{0, 0, 1, 0, 1};

   initial begin
      u_if.load = 1'b0; u_if.load_val = 8'd0; u_if.oneshot = 1'b0;
      u_if.en = 1'b0;   u_if.stop = 1'b0;
      step(3);
      reset_n = 1'b1;

      // After reset: enable alone does nothing.
      u_if.en = 1'b1;
      step(3);
      chk("rst_count", int'(u_if.count), 0);
      chk("rst_tick",  int'(u_if.tick), 0);
      chk("rst_busy",  int'(u_if.busy), 0);
      chk("rst_done",  int'(u_if.done), 0);

      // Asynchronous reset pulse between edges.
      u_if.load = 1'b1; u_if.load_val = 8'd3;
      step(1);
      u_if.load = 1'b0;
      step(1);
      chk("pulse_pre_count", int'(u_if.count), 2);
      #1 reset_n = 1'b0;
      #1;
      chk("pulse_count", int'(u_if.count), 0);
      chk("pulse_busy",  int'(u_if.busy), 0);
      #1 reset_n = 1'b1;
      step(1);
      chk("pulse_idle_busy", int'(u_if.busy), 0);

      // Periodic N=3.
      u_if.load = 1'b1; u_if.load_val = 8'd3; u_if.oneshot = 1'b0;
      step(1);
      u_if.load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("per_count", int'(u_if.count), pc[i]);
         chk("per_tick",  int'(u_if.tick),  pt[i]);
         step(1);
      end

      // Periodic N=0: tick every enabled cycle.
      u_if.load = 1'b1; u_if.load_val = 8'd0;
      step(1);
      u_if.load = 1'b0;
      chk("n0_tick0", int'(u_if.tick), 0);
      chk("n0_busy",  int'(u_if.busy), 1);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("n0_tick",  int'(u_if.tick), 1);
         chk("n0_count", int'(u_if.count), 0);
      end

      // Pause for 2 cycles at count=2.
      u_if.load = 1'b1; u_if.load_val = 8'd3;
      step(1);
      u_if.load = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("pause_count", int'(u_if.count), qc[i]);
         chk("pause_tick",  int'(u_if.tick),  qt[i]);
         if (i < 6) begin
            u_if.en = qe[i][0];
            step(1);
         end
      end

      // One-shot N=2.
      u_if.load = 1'b1; u_if.load_val = 8'd2; u_if.oneshot = 1'b1;
      step(1);
      u_if.load = 1'b0; u_if.oneshot = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("os_count", int'(u_if.count), oc[i]);
         chk("os_tick",  int'(u_if.tick),  ot[i]);
         chk("os_done",  int'(u_if.done),  ot[i]);
         chk("os_busy",  int'(u_if.busy),  ob[i]);
         if (i < 3) step(1);
      end
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("os_hold_done", int'(u_if.done), 1);
         chk("os_hold_tick", int'(u_if.tick), 0);
      end
      u_if.load = 1'b1; u_if.load_val = 8'd2;
      step(1);
      u_if.load = 1'b0;
      chk("os_reload_done",  int'(u_if.done), 0);
      chk("os_reload_busy",  int'(u_if.busy), 1);
      chk("os_reload_count", int'(u_if.count), 2);
      step(1);
      chk("os_reload_dec", int'(u_if.count), 1);

      // Mid-run reload, load+stop, then stop.
      u_if.load = 1'b1; u_if.load_val = 8'd5;
      step(1);
      u_if.load = 1'b0;
      step(3);
      chk("mid_at2", int'(u_if.count), 2);
      u_if.load = 1'b1; u_if.load_val = 8'd1;
      step(1);
      u_if.load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("mid_count", int'(u_if.count), mc[i]);
         chk("mid_tick",  int'(u_if.tick),  mt[i]);
         if (i < 4) step(1);
      end
      u_if.load = 1'b1; u_if.stop = 1'b1; u_if.load_val = 8'd4;
      step(1);
      u_if.load = 1'b0; u_if.stop = 1'b0;
      chk("ls_busy",  int'(u_if.busy), 1);
      chk("ls_count", int'(u_if.count), 4);
      step(1);
      chk("ls_dec", int'(u_if.count), 3);
      u_if.stop = 1'b1;
      step(1);
      u_if.stop = 1'b0;
      chk("stop_count", int'(u_if.count), 0);
      chk("stop_busy",  int'(u_if.busy), 0);
      chk("stop_tick",  int'(u_if.tick), 0);
      step(1);
      chk("stop_hold", int'(u_if.count), 0);

      // Reset mid-run at count=1.
      u_if.load = 1'b1; u_if.load_val = 8'd4;
      step(1);
      u_if.load = 1'b0;
      step(3);
      chk("rmid_at1", int'(u_if.count), 1);
      #1 reset_n = 1'b0;
      #1;
      chk("rmid_count", int'(u_if.count), 0);
      chk("rmid_busy",  int'(u_if.busy), 0);
      step(2);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("rmid_tick",  int'(u_if.tick), 0);
         chk("rmid_idle",  int'(u_if.count), 0);
         chk("rmid_ibusy", int'(u_if.busy), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Sequential down-counter that is the decrementing counterpart of the incrementer used by the game's step counters. It is loaded with a count and decrements it by one on each enabled cycle. When the count reaches zero it emits a one-cycle `tick`. Periodic mode reloads the count; one-shot mode stops and raises `done`. Sits between the clock divider and the Tetris control FSM, where it generates the gravity drop interval and fixed delays such as line-clear flash and game-over hold.

## Interface
- `WIDTH`, default 8: width of the count and reload value.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset; forces every register to its reset value immediately.
- `load`, input, 1: synchronous; captures `load_val` into the reload register and into `count`, and enters RUN.
- `load_val`, input, WIDTH: start and reload value N.
- `oneshot`, input, 1: sampled with `load`. 1 selects one-shot mode; 0 selects periodic mode.
- `en`, input, 1: count enable; 0 pauses in RUN.
- `stop`, input, 1: synchronous abort to IDLE.
- `count`, output, WIDTH: current count (registered).
- `tick`, output, 1: registered one-cycle pulse at terminal count.
- `busy`, output, 1: 1 while in RUN.
- `done`, output, 1: 1 while in DONE (one-shot completed).

## Operation
- The state is held in two bits.
- States:
  - IDLE: reset state. `count` = 0, no decrement.
  - RUN: counting.
  - DONE: one-shot finished. `count` = 0 and is held.
- Per-edge priority, highest first:
  1. `load`: count ← `load_val`, reload ← `load_val`, mode ← `oneshot`, state ← RUN, tick ← 0.
  2. `stop`: state ← IDLE, count ← 0, tick ← 0. Reload and mode are kept.
  3. RUN and `en`=1:
     - If count ≠ 0: count ← count − 1, tick ← 0.
     - If count = 0: tick ← 1.
       - Periodic mode: count ← reload, stay in RUN.
       - One-shot mode: state ← DONE, count stays 0.
  4. Otherwise: hold count and state, tick ← 0.
- The decrement is plain WIDTH-bit subtraction. It never wraps, because zero is handled by the reload or stop rule above and is never decremented.
- In periodic mode with N=0, `tick` is 1 on every enabled cycle.
- In IDLE and DONE, `en` has no effect. Only `load` leaves these states; `stop` moves DONE to IDLE.
- Reset values:
  - `count`, reload register, mode, `tick`, `busy`, `done`: all 0.
  - State: IDLE.
- Reset asserted mid-run abandons the count immediately. No `tick` is produced.

## Timing
- `load` is high in cycle k:
  - After edge k+1, `count` = N and `busy` = 1.
  - Decrements start on the next enabled edge.
- Periodic mode with `en` held at 1:
  - The count sequence is N, N−1, …, 0, N, …
  - `tick` is high in the cycle after `count` showed 0, coincident with `count` = N.
  - Period is N+1 cycles.
- One-shot mode with `en` held at 1:
  - `tick` and `done` rise together N+1 edges after the load edge.
  - `busy` falls on that same edge.
  - `tick` lasts exactly 1 cycle; `done` holds until `load` or `stop`.
- `en` low for M cycles stretches the sequence by exactly M cycles. The count holds and no tick is generated while `en` is low.
- `load` during RUN restarts from the new N on the next edge and suppresses a tick due on that same edge.
- `load` and `stop` in the same cycle: `load` wins.
- Every output is registered. There is no combinational path from any input to any output.

## Test plan
- Reset and pulse checks: release `reset_n`, then pulse `reset_n` low between edges.
  - After release: `count` = 0, `tick`/`busy`/`done` = 0, and `en`=1 alone causes no change.
  - On the asynchronous pulse: outputs clear immediately, without waiting for an edge.
- Periodic mode: `load_val`=3, `oneshot`=0, `en`=1.
  - `count` runs 3,2,1,0,3,2,… and `tick` fires every 4 cycles.
  - Repeat with N=0: `tick` is high on every cycle.
- Pause: N=3 periodic, `en` dropped for 2 cycles at `count`=2.
  - `count` holds at 2 for those 2 cycles.
  - The tick arrives 2 cycles later than in the unpaused run.
- One-shot mode: N=2, `oneshot`=1.
  - `count` runs 2,1,0.
  - `tick`=1 for 1 cycle together with `done`=1 and `busy`=0.
  - `done` stays high for 10 further cycles; a `load` then clears it and restarts counting.
- Mid-run controls: N=5 periodic, with `load_val`=1 loaded at `count`=2.
  - `count` becomes 1,0,1,0… and the old tick does not occur.
  - Then assert `load` and `stop` together: RUN is re-entered.
  - Then `stop` alone: IDLE with `count`=0.
- Reset mid-run: N=4 periodic, `reset_n` asserted at `count`=1.
  - No tick is produced, and the block is in IDLE with `count`=0.
